// File: rtl/counter_pkg.sv
// Shared types and constants for the counter_ctl timing/event counter.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cnt_state_t;

  localparam logic DIR_UP       = 1'b1;
  localparam logic MODE_FREE    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/counter_ctl_clk_en_div.sv
// Clock-enable prescaler: emits a one-cycle tick once every PRESCALE enabled cycles.
module clk_en_div #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic sync_clr,
  output logic tick
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_d;

  // Phase only moves while en is high, so dropping en freezes it mid-period.
  always_comb begin
    tick  = en && (pre_q == LAST);
    pre_d = pre_q;
    if (sync_clr) begin
      pre_d = '0;
    end else if (en) begin
      pre_d = tick ? '0 : pre_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/counter_ctl.sv
// Parametrised modulo counter with prescaler, up/down, clear/load and one-shot FSM.
module counter_ctl
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_VAL   = 2**WIDTH - 1,
  parameter int unsigned PRESCALE  = 1,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic             mode,
  input  logic             start,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  if (MAX_VAL < 1) begin : g_chk_max_lo
    $error("counter_ctl: MAX_VAL must be >= 1");
  end
  if (64'(MAX_VAL) > ((64'd1 << WIDTH) - 64'd1)) begin : g_chk_max_hi
    $error("counter_ctl: MAX_VAL must fit in WIDTH bits");
  end
  if (PRESCALE < 1) begin : g_chk_presc
    $error("counter_ctl: PRESCALE must be >= 1");
  end
  if (RESET_VAL > MAX_VAL) begin : g_chk_rst
    $error("counter_ctl: RESET_VAL must be <= MAX_VAL");
  end

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_W = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  cnt_state_t       state_q, state_d;

  logic             oneshot;
  logic             start_ok;
  logic             sync_clr;
  logic             tick;
  logic             step_en;
  logic             at_wrap;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] term_val;

  always_comb begin
    oneshot  = (mode != MODE_FREE);
    start_ok = oneshot && start;
    sync_clr = clr || load || start_ok;
  end

  clk_en_div #(
    .PRESCALE(PRESCALE)
  ) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .sync_clr(sync_clr),
    .tick    (tick)
  );

  always_comb begin
    if (dir == DIR_UP) begin
      at_wrap  = (count_q == MAX_W);
      step_val = at_wrap ? '0 : count_q + WIDTH'(1);
      term_val = MAX_W;
    end else begin
      at_wrap  = (count_q == '0);
      step_val = at_wrap ? MAX_W : count_q - WIDTH'(1);
      term_val = '0;
    end
    step_en = tick && (!oneshot || (state_q == RUN));
  end

  // Priority clr > load > start > step; leaving one-shot mode parks the FSM in IDLE.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q && !ovf_clr;
    state_d = oneshot ? state_q : IDLE;
    if (clr) begin
      count_d = RST_W;
      state_d = IDLE;
    end else if (load) begin
      count_d = (load_val > MAX_W) ? MAX_W : load_val;
    end else if (start_ok) begin
      count_d = (dir == DIR_UP) ? '0 : MAX_W;
      state_d = RUN;
    end else if (step_en) begin
      count_d = step_val;
      if (!oneshot) begin
        if (at_wrap) begin
          tc_d  = 1'b1;
          ovf_d = 1'b1;
        end
      end else if (step_val == term_val) begin
        tc_d    = 1'b1;
        state_d = DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= RST_W;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
      state_q <= IDLE;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    count = count_q;
    tc    = tc_q;
    ovf   = ovf_q;
    done  = (state_q == DONE);
    busy  = (mode == MODE_ONESHOT) ? (state_q == RUN) : en;
  end

endmodule

// File: tb/tb_counter_ctl.sv
// Bench for counter_ctl: directed vectors, literal checks and a per-cycle behavioural model.
module tb_counter_ctl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, clr, load, dir, mode, start, ovf_clr;
  logic [3:0] load_val;
  logic [3:0] cnt1;
  logic       tc1, busy1, done1, ovf1;

  logic       en4;
  logic [3:0] cnt4;
  logic       tc4, busy4, done4, ovf4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  counter_ctl #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(1), .RESET_VAL(0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load), .load_val(load_val),
    .dir(dir), .mode(mode), .start(start), .ovf_clr(ovf_clr),
    .count(cnt1), .tc(tc1), .busy(busy1), .done(done1), .ovf(ovf1)
  );

  counter_ctl #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(4), .RESET_VAL(0)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en4), .clr(1'b0), .load(1'b0), .load_val(4'd0),
    .dir(1'b1), .mode(1'b0), .start(1'b0), .ovf_clr(1'b0),
    .count(cnt4), .tc(tc4), .busy(busy4), .done(done4), .ovf(ovf4)
  );

  // Model state: st 0 = idle, 1 = running, 2 = finished.
  typedef struct {
    int count;
    bit tc;
    bit ovf;
    int st;
    int pre;
  } ms_t;

  localparam ms_t M_RESET = '{count: 0, tc: 1'b0, ovf: 1'b0, st: 0, pre: 0};

  ms_t m1 = M_RESET;
  ms_t m4 = M_RESET;

  function automatic ms_t mstep(ms_t s, bit e, bit c, bit ld, int lv, bit d, bit m,
                                bit st, bit oc, int maxv, int presc);
    ms_t n = s;
    bit  tick;
    bit  wrap;
    int  nxt;
    n.tc = 1'b0;
    if (!m) n.st = 0;
    if (oc) n.ovf = 1'b0;
    tick = e && (s.pre == presc - 1);
    if (e) n.pre = tick ? 0 : s.pre + 1;
    if (c) begin
      n.count = 0; n.pre = 0; n.st = 0;
    end else if (ld) begin
      n.count = (lv > maxv) ? maxv : lv; n.pre = 0;
    end else if (m && st) begin
      n.st = 1; n.count = d ? 0 : maxv; n.pre = 0;
    end else if (tick && (!m || s.st == 1)) begin
      wrap    = d ? (s.count == maxv) : (s.count == 0);
      nxt     = d ? (wrap ? 0 : s.count + 1) : (wrap ? maxv : s.count - 1);
      n.count = nxt;
      if (!m) begin
        if (wrap) begin n.tc = 1'b1; n.ovf = 1'b1; end
      end else if (nxt == (d ? maxv : 0)) begin
        n.tc = 1'b1; n.st = 2;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1 = M_RESET;
      m4 = M_RESET;
    end else begin
      m1 = mstep(m1, en, clr, load, int'(load_val), dir, mode, start, ovf_clr, 9, 1);
      m4 = mstep(m4, en4, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 9, 4);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("m_count", 32'(cnt1), 32'(m1.count));
    chk("m_tc", 32'(tc1), 32'(m1.tc));
    chk("m_ovf", 32'(ovf1), 32'(m1.ovf));
    chk("m_done", 32'(done1), 32'(m1.st == 2));
    chk("m_busy", 32'(busy1), 32'(mode ? (m1.st == 1) : en));
    chk("m4_count", 32'(cnt4), 32'(m4.count));
    chk("m4_tc", 32'(tc4), 32'(m4.tc));
    chk("m4_ovf", 32'(ovf4), 32'(m4.ovf));
    chk("m4_busy", 32'(busy4), 32'(en4));
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; load = 1'b0; load_val = 4'd0;
    dir = 1'b1; mode = 1'b0; start = 1'b0; ovf_clr = 1'b0; en4 = 1'b0;
    #12;
    chk("rst_count", 32'(cnt1), 0);
    chk("rst_tc", 32'(tc1), 0);
    chk("rst_ovf", 32'(ovf1), 0);
    chk("rst_done", 32'(done1), 0);
    chk("rst_busy", 32'(busy1), 0);
    step(1);
    rst_n = 1'b1;

    // free-run up through a wrap
    en = 1'b1; dir = 1'b1; mode = 1'b0;
    step(10);
    chk("fr_wrap_count", 32'(cnt1), 0);
    chk("fr_wrap_tc", 32'(tc1), 1);
    chk("fr_wrap_ovf", 32'(ovf1), 1);
    step(1);
    chk("fr_after_count", 32'(cnt1), 1);
    chk("fr_after_tc", 32'(tc1), 0);
    ovf_clr = 1'b1;
    step(1);
    chk("fr_ovfclr", 32'(ovf1), 0);
    ovf_clr = 1'b0;

    // load then count down through a wrap
    load = 1'b1; load_val = 4'd3;
    step(1);
    chk("ld3_count", 32'(cnt1), 3);
    load = 1'b0; dir = 1'b0;
    step(3);
    chk("dn_zero_count", 32'(cnt1), 0);
    chk("dn_zero_tc", 32'(tc1), 0);
    step(1);
    chk("dn_wrap_count", 32'(cnt1), 9);
    chk("dn_wrap_tc", 32'(tc1), 1);
    load = 1'b1; load_val = 4'd12;
    step(1);
    chk("ld_sat_count", 32'(cnt1), 9);
    clr = 1'b1;
    step(1);
    chk("clr_over_load", 32'(cnt1), 0);
    clr = 1'b0; load = 1'b0; en = 1'b0; ovf_clr = 1'b1;
    step(1);
    chk("ovf_cleared", 32'(ovf1), 0);
    ovf_clr = 1'b0;

    // one-shot up
    mode = 1'b1; dir = 1'b1; en = 1'b1; start = 1'b1;
    step(1);
    chk("os_start_count", 32'(cnt1), 0);
    chk("os_start_busy", 32'(busy1), 1);
    start = 1'b0;
    step(8);
    chk("os_8_count", 32'(cnt1), 8);
    chk("os_8_done", 32'(done1), 0);
    step(1);
    chk("os_term_count", 32'(cnt1), 9);
    chk("os_term_tc", 32'(tc1), 1);
    chk("os_term_done", 32'(done1), 1);
    chk("os_term_busy", 32'(busy1), 0);
    chk("os_term_ovf", 32'(ovf1), 0);
    step(5);
    chk("os_hold_count", 32'(cnt1), 9);
    chk("os_hold_tc", 32'(tc1), 0);
    start = 1'b1;
    step(1);
    chk("os_restart_count", 32'(cnt1), 0);
    chk("os_restart_busy", 32'(busy1), 1);
    start = 1'b0;

    // asynchronous reset mid-run
    step(5);
    chk("os_run5_count", 32'(cnt1), 5);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(cnt1), 0);
    chk("arst_busy", 32'(busy1), 0);
    chk("arst_done", 32'(done1), 0);
    step(1);
    rst_n = 1'b1;
    step(1);
    chk("arst_idle_busy", 32'(busy1), 0);
    chk("arst_idle_count", 32'(cnt1), 0);

    // wrap and ovf_clr in the same cycle
    mode = 1'b0; dir = 1'b1; load = 1'b1; load_val = 4'd9;
    step(1);
    load = 1'b0; ovf_clr = 1'b1;
    step(1);
    chk("setwins_count", 32'(cnt1), 0);
    chk("setwins_ovf", 32'(ovf1), 1);
    ovf_clr = 1'b0; en = 1'b0;

    // prescale by 4 with an enable gap
    en4 = 1'b1;
    step(3);
    chk("p4_3_count", 32'(cnt4), 0);
    step(1);
    chk("p4_4_count", 32'(cnt4), 1);
    step(2);
    en4 = 1'b0;
    step(3);
    chk("p4_frozen", 32'(cnt4), 1);
    en4 = 1'b1;
    step(1);
    chk("p4_resume1", 32'(cnt4), 1);
    step(1);
    chk("p4_resume2", 32'(cnt4), 2);

    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_ctl.md
Name: counter_ctl

Overview:
Parametrised modulo counter; the successor to the fixed 4-bit free-running counter. Adds configurable width and modulus, up/down direction, a clock-enable prescaler, synchronous clear/load, and a one-shot mode with a small control FSM. Intended as the general timing/event counter for the hello-level designs and their benches.

Parameters:
WIDTH, 8, counter width in bits
MAX_VAL, 2**WIDTH-1, terminal value; count range is 0..MAX_VAL (modulus MAX_VAL+1); must be >= 1 and <= 2**WIDTH-1
PRESCALE, 1, count steps once per PRESCALE enabled cycles; must be >= 1
RESET_VAL, 0, count value after reset and after clr; must be <= MAX_VAL

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  count enable; also gates the prescaler
clr  in  1  synchronous clear to RESET_VAL
load  in  1  synchronous load of load_val
load_val  in  WIDTH  load value
dir  in  1  1 = up, 0 = down
mode  in  1  0 = free-run (wrap), 1 = one-shot
start  in  1  one-shot start/restart pulse; ignored when mode=0
ovf_clr  in  1  clears the sticky ovf flag
count  out  WIDTH  current count, registered
tc  out  1  terminal-count pulse, registered, 1 cycle
busy  out  1  one-shot FSM in RUN; in free-run mode, equals en
done  out  1  one-shot FSM in DONE
ovf  out  1  sticky: set on any free-run wrap

Behaviour:
- Reset (rst_n=0, async): count=RESET_VAL, tc=0, done=0, ovf=0, prescaler=0, FSM=IDLE; busy reflects the reset state (0 in mode 1).
- Priority each cycle: clr > load > start > step.
- clr: count<=RESET_VAL, prescaler<=0, FSM<=IDLE, tc<=0.
- load: count<=min(load_val, MAX_VAL) (saturates), prescaler<=0, FSM unchanged, tc<=0.
- Prescaler: advances only when en=1. tick=1 when en=1 and prescaler==PRESCALE-1; the prescaler then returns to 0. With PRESCALE=1, tick=en.
- Step occurs on tick. In mode 1, a step also requires FSM=RUN.
- Up step: count==MAX_VAL wraps to 0, else count+1. Down step: count==0 wraps to MAX_VAL, else count-1.
- Latency: count changes on the edge following the tick cycle. tc is high in the same cycle that count first shows the wrapped or terminal value.
- Free-run (mode 0): tc pulses on each wrap; ovf<=1 on each wrap.
- ovf_clr clears ovf. If ovf_clr and a wrap occur in the same cycle, the set wins.
- One-shot FSM states: IDLE, RUN, DONE.
  - IDLE/DONE + start -> RUN. Count is preset to 0 if dir=1, else MAX_VAL. Prescaler<=0.
  - RUN + step reaching the terminal value (MAX_VAL if up, 0 if down) -> DONE. Count holds the terminal value; tc pulses once; ovf is not set.
  - RUN + start -> restart: same preset, stays in RUN.
  - DONE holds until start or clr.
- Changing dir mid-RUN takes effect on the next step; the terminal target follows the current dir.
- Changing mode mid-operation: FSM<=IDLE on the next edge; count holds.
- Async reset mid-operation forces all reset values immediately, without waiting for a clock edge.

Decomposition:
- Package counter_pkg: typedef enum logic [1:0] {IDLE, RUN, DONE} cnt_state_t; localparams DIR_UP=1'b1, MODE_FREE=1'b0, MODE_ONESHOT=1'b1.
- Sub-module clk_en_div (parameter PRESCALE; ports clk, rst_n, en, sync_clr, tick), instantiated once.
- Elaboration-time assertions: MAX_VAL, PRESCALE and RESET_VAL within their legal ranges.

Test Plan:
- All scenarios use WIDTH=4, MAX_VAL=9, PRESCALE=1, RESET_VAL=0, 10 ns clock, unless stated.
- Reset then en=1, dir=1, mode=0 for 12 cycles -> count 0,1..9,0,1; tc high only in the cycle count=0 after 9; ovf=1 from then; ovf_clr -> ovf=0.
- load with load_val=3, then dir=0, en=1 -> count 3,2,1,0,9 with tc at 9. load_val=12 -> count=9 (saturated). clr and load asserted together -> count=0.
- mode=1, dir=1, start pulse -> busy=1, count 0..9. At 9: done=1, busy=0, single tc pulse, ovf stays 0. Count holds at 9 for 5 further cycles. Second start -> count=0, RUN.
- PRESCALE=4 instance, free-run up -> count increments every 4th cycle. Dropping en for 3 cycles mid-period freezes both count and prescaler phase.
- Assert rst_n=0 asynchronously (mid-cycle) while in RUN at count=5 -> count=0, done=0, busy=0 immediately, before the next clk edge; after release the FSM is IDLE.
- Free-run wrap (9->0) in the same cycle as ovf_clr -> ovf=1.
